// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: turns trap, memory-wait, branch and load-use events into
// per-register stall/flush masks, with a dmem wait FSM, a watchdog and saturating counters.
module pipe_hazard_ctrl #(
  parameter int NUM_REGS     = 5,
  parameter int HAZ_REG      = 2,
  parameter int BR_REG       = 2,
  parameter int MEM_REG      = 3,
  parameter int DRAIN_CYCLES = 1,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trap,
  input  logic                dmem_busy,
  input  logic                imem_busy,
  input  logic                branch_taken,
  input  logic                load_use,
  input  logic                cnt_clr,
  output logic [NUM_REGS-1:0] stall,
  output logic [NUM_REGS-1:0] flush,
  output logic [1:0]          state_o,
  output logic                mem_timeout,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int              WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX     = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_SET     = WD_W'(TIMEOUT - 1);
  localparam logic [2:0]      DRAIN_LAST = 3'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  state_t          state, state_nxt;
  logic            redirect_pend, pend_nxt;
  logic [2:0]      drain_cnt, drain_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            dmem_class;
  logic            accept_evt;

  always_comb begin
    stall      = '0;
    flush      = '0;
    state_nxt  = state;
    drain_nxt  = drain_cnt;
    pend_nxt   = redirect_pend;
    accept_evt = 1'b0;
    // Once dmem completes the MEM stage may advance, so a DWAIT cycle with dmem idle is not dmem-class.
    dmem_class = (state == DRAIN) || (dmem_busy && (state == RUN || state == DWAIT));

    case (state)
      RUN:   if (dmem_busy) state_nxt = DWAIT;
      DWAIT: begin
        if (!dmem_busy) begin
          if (imem_busy && DRAIN_CYCLES > 0) begin
            state_nxt = DRAIN;
            drain_nxt = 3'd0;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = RUN;
        else                         drain_nxt = drain_cnt + 3'd1;
      end
      default: state_nxt = RUN;
    endcase

    if (trap) begin
      for (int i = 1; i < NUM_REGS; i++) flush[i] = 1'b1;
      state_nxt  = RUN;
      drain_nxt  = 3'd0;
      pend_nxt   = 1'b0;
      accept_evt = 1'b1;
    end else if (dmem_class) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i <= MEM_REG)     stall[i] = 1'b1;
        if (i == MEM_REG + 1) flush[i] = 1'b1;
      end
    end else if (branch_taken) begin
      // The branch itself already flushes IF/ID, so a pending redirect is absorbed here.
      for (int i = 1; i < NUM_REGS; i++) if (i <= BR_REG) flush[i] = 1'b1;
      pend_nxt   = imem_busy;
      accept_evt = 1'b1;
    end else begin
      if (load_use) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (i < HAZ_REG)  stall[i] = 1'b1;
          if (i == HAZ_REG) flush[i] = 1'b1;
        end
      end else if (imem_busy) begin
        stall[0] = 1'b1;
        flush[1] = 1'b1;
      end
      // The fetch that was in flight at redirect time carries a stale instruction: drop it.
      if (redirect_pend && !imem_busy) begin
        stall[0] = 1'b1;
        flush[1] = 1'b1;
        pend_nxt = 1'b0;
      end
    end

    if (reset) begin
      stall = '0;
      flush = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      redirect_pend <= 1'b0;
      drain_cnt     <= 3'd0;
      wd_cnt        <= '0;
      mem_timeout   <= 1'b0;
      stall_cnt     <= '0;
      flush_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      redirect_pend <= pend_nxt;
      drain_cnt     <= drain_nxt;

      if (state == DWAIT) begin
        if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WD_W'(1);
      end else begin
        wd_cnt <= '0;
      end

      if (cnt_clr)                                 mem_timeout <= 1'b0;
      else if (state == DWAIT && wd_cnt >= WD_SET) mem_timeout <= 1'b1;

      if (cnt_clr)                        stall_cnt <= '0;
      else if (|stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);

      if (cnt_clr)                          flush_cnt <= '0;
      else if (accept_evt && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle stall/flush/state expectations go through a
// scoreboard queue; counters and flags are checked against hand-derived constants.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       trap, dmem_busy, imem_busy, branch_taken, load_use, cnt_clr;
  logic [4:0] stall, flush;
  logic [1:0] state_o;
  logic       mem_timeout;
  logic [3:0] stall_cnt, flush_cnt;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [4:0] s;
    logic [4:0] f;
    logic [1:0] st;
  } exp_t;
  exp_t sb[$];

  pipe_hazard_ctrl #(
    .NUM_REGS(5), .HAZ_REG(2), .BR_REG(2), .MEM_REG(3),
    .DRAIN_CYCLES(1), .TIMEOUT(16), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .trap(trap), .dmem_busy(dmem_busy), .imem_busy(imem_busy),
    .branch_taken(branch_taken), .load_use(load_use), .cnt_clr(cnt_clr),
    .stall(stall), .flush(flush), .state_o(state_o), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, queue what the DUT must show, compare mid-cycle.
  task automatic cyc(input string tag, input logic t, input logic d, input logic i,
                     input logic b, input logic l,
                     input logic [4:0] es, input logic [4:0] ef, input logic [1:0] est);
    exp_t e;
    @(posedge clk);
    #1;
    trap = t; dmem_busy = d; imem_busy = i; branch_taken = b; load_use = l;
    sb.push_back('{s: es, f: ef, st: est});
    @(negedge clk);
    e = sb.pop_front();
    check({tag, ".stall"}, 32'(stall), 32'(e.s));
    check({tag, ".flush"}, 32'(flush), 32'(e.f));
    check({tag, ".state"}, 32'(state_o), 32'(e.st));
  endtask

  initial begin
    reset = 1'b1; trap = 0; dmem_busy = 1'b1; imem_busy = 0; branch_taken = 0;
    load_use = 0; cnt_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.flush", 32'(flush), 32'd0);
    check("rst.state", 32'(state_o), 32'd0);
    check("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst.flush_cnt", 32'(flush_cnt), 32'd0);
    check("rst.timeout", 32'(mem_timeout), 32'd0);
    dmem_busy = 0;
    @(negedge clk);
    reset = 1'b0;

    // dmem wait, imem idle
    for (int k = 0; k < 3; k++) cyc("dwait", 0, 1, 0, 0, 0, 5'b01111, 5'b10000, (k == 0) ? 2'd0 : 2'd1);
    cyc("dwait_end", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd1);
    cyc("dwait_run", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0);
    check("dwait.stall_cnt", 32'(stall_cnt), 32'd3);

    // dmem completes while imem is busy -> one drain cycle
    cyc("drain_a", 0, 1, 1, 0, 0, 5'b01111, 5'b10000, 2'd0);
    cyc("drain_b", 0, 1, 1, 0, 0, 5'b01111, 5'b10000, 2'd1);
    cyc("drain_fall", 0, 0, 1, 0, 0, 5'b00001, 5'b00010, 2'd1);
    cyc("drain_cyc", 0, 0, 0, 0, 0, 5'b01111, 5'b10000, 2'd2);
    cyc("drain_run", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0);
    check("drain.stall_cnt", 32'(stall_cnt), 32'd7);

    // branch beats load_use
    cyc("br_lu", 0, 0, 0, 1, 1, 5'b00000, 5'b00110, 2'd0);
    cyc("br_lu_idle", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0);
    check("br_lu.flush_cnt", 32'(flush_cnt), 32'd1);

    // branch while a fetch is outstanding -> redirect discard when imem frees
    cyc("redir_br", 0, 0, 1, 1, 0, 5'b00000, 5'b00110, 2'd0);
    cyc("redir_wait", 0, 0, 1, 0, 0, 5'b00001, 5'b00010, 2'd0);
    cyc("redir_fire", 0, 0, 0, 0, 0, 5'b00001, 5'b00010, 2'd0);
    cyc("redir_done", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0);
    check("redir.flush_cnt", 32'(flush_cnt), 32'd2);
    check("redir.stall_cnt", 32'(stall_cnt), 32'd9);

    // load_use alone, and load_use over imem
    cyc("lu", 0, 0, 0, 0, 1, 5'b00011, 5'b00100, 2'd0);
    cyc("lu_imem", 0, 0, 1, 0, 1, 5'b00011, 5'b00100, 2'd0);

    // trap during DWAIT
    cyc("trap_a", 0, 1, 0, 0, 0, 5'b01111, 5'b10000, 2'd0);
    cyc("trap_b", 1, 1, 0, 0, 0, 5'b00000, 5'b11110, 2'd1);
    cyc("trap_run", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0);
    check("trap.flush_cnt", 32'(flush_cnt), 32'd3);
    check("trap.stall_cnt", 32'(stall_cnt), 32'd12);

    // dmem-class ignores branch and load_use
    cyc("dm_br", 0, 1, 0, 1, 1, 5'b01111, 5'b10000, 2'd0);
    cyc("dm_br_end", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd1);
    cyc("dm_br_run", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0);
    check("dm_br.flush_cnt", 32'(flush_cnt), 32'd3);

    // trap cancels a pending redirect
    cyc("tp_br", 0, 0, 1, 1, 0, 5'b00000, 5'b00110, 2'd0);
    cyc("tp_trap", 1, 0, 1, 0, 0, 5'b00000, 5'b11110, 2'd0);
    cyc("tp_after", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0);
    check("tp.flush_cnt", 32'(flush_cnt), 32'd5);

    // watchdog: one DWAIT cycle short of TIMEOUT
    for (int k = 0; k < 15; k++) cyc("wd15", 0, 1, 0, 0, 0, 5'b01111, 5'b10000, (k == 0) ? 2'd0 : 2'd1);
    cyc("wd15_end", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd1);
    cyc("wd15_run", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0);
    check("wd15.timeout", 32'(mem_timeout), 32'd0);
    check("sat.stall_cnt", 32'(stall_cnt), 32'd15);

    // watchdog: exactly TIMEOUT DWAIT cycles
    for (int k = 0; k < 16; k++) cyc("wd16", 0, 1, 0, 0, 0, 5'b01111, 5'b10000, (k == 0) ? 2'd0 : 2'd1);
    cyc("wd16_end", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd1);
    cyc("wd16_run", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0);
    check("wd16.timeout", 32'(mem_timeout), 32'd1);
    cyc("wd16_hold", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0);
    check("wd16.sticky", 32'(mem_timeout), 32'd1);

    // clear wins over a same-cycle stall increment
    @(posedge clk);
    #1;
    cnt_clr = 1'b1; load_use = 1'b1;
    @(negedge clk);
    check("clr.stall", 32'(stall), 32'b00011);
    @(posedge clk);
    #1;
    cnt_clr = 1'b0; load_use = 1'b0;
    @(negedge clk);
    check("clr.stall_cnt", 32'(stall_cnt), 32'd0);
    check("clr.flush_cnt", 32'(flush_cnt), 32'd0);
    check("clr.timeout", 32'(mem_timeout), 32'd0);

    // asynchronous reset aborts a DWAIT
    cyc("ar_a", 0, 1, 0, 0, 0, 5'b01111, 5'b10000, 2'd0);
    cyc("ar_b", 0, 1, 0, 0, 0, 5'b01111, 5'b10000, 2'd1);
    reset = 1'b1;
    #1;
    check("ar.state", 32'(state_o), 32'd0);
    check("ar.stall", 32'(stall), 32'd0);
    check("ar.flush", 32'(flush), 32'd0);
    @(negedge clk);
    dmem_busy = 1'b0;
    reset = 1'b0;
    cyc("ar_run", 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
